// File: rtl/instr_mem_resp.sv
// Purpose: instruction-memory responder; word-indexed fetch with error flagging, flush and program-load port.
// Latency: a request accepted at edge N is presented on rsp_* after edge N+LATENCY at the earliest.
// Backpressure: LATENCY+1 credits across pipeline and response FIFO; req_ready is a function of registered state only.
//
// Ports:
//   clk                      rising-edge clock for all state
//   rst                      asynchronous active-low reset (memory array is not reset)
//   req_valid/req_ready      fetch request handshake, req_addr = byte address (fetch PC)
//   rsp_valid/rsp_ready      response handshake, rsp_instr/rsp_err = FIFO head
//   flush                    drop every in-flight and queued response (request in the same cycle survives)
//   ld_en/ld_addr/ld_data    program-load write port, misaligned or out-of-range loads are dropped
module instr_mem_resp #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic        rsp_err,
   input  logic        flush,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam int          FD       = LATENCY + 1;
   localparam int          PW       = $clog2(FD);
   localparam int          CW       = $clog2(FD + 1);
   localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
   localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);
   localparam logic [CW-1:0] FD_CNT   = CW'(FD);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [31:0]        r_mem [DEPTH_WORDS];

   logic [LATENCY-1:0] r_stg_vld;
   logic [LATENCY-1:0] w_stg_vld_nxt;
   logic [31:0]        r_stg_instr [LATENCY];
   logic [LATENCY-1:0] r_stg_err;

   logic [31:0]        r_fifo_instr [FD];
   logic [FD-1:0]      r_fifo_err;
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;

   // ------------------------------------------------------------------
   // Request / load decode
   // ------------------------------------------------------------------
   logic          w_req_acc;
   logic          w_req_err;
   logic [AW-1:0] w_req_idx;
   logic          w_ld_ok;
   logic [AW-1:0] w_ld_idx;
   logic          w_push;
   logic          w_pop;
   logic [CW:0]   w_used;

   assign w_req_acc = req_valid && req_ready;
   assign w_req_idx = req_addr[AW+1:2];
   assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_L);

   assign w_ld_idx  = ld_addr[AW+1:2];
   assign w_ld_ok   = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < DEPTH_L);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // ------------------------------------------------------------------
   // Memory array: no reset, contents survive rst.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin : mem_write
      if (w_ld_ok) begin
         r_mem[w_ld_idx] <= ld_data;
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline data path. The array read samples the pre-edge
   // contents, so a same-cycle load to the same word is not visible to
   // this request (read-before-write).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin : stg_data
      if (w_req_acc) begin
         r_stg_instr[0] <= w_req_err ? NOP_INSTR : r_mem[w_req_idx];
         r_stg_err[0]   <= w_req_err;
      end
      for (int i = 1; i < LATENCY; i++) begin
         r_stg_instr[i] <= r_stg_instr[i-1];
         r_stg_err[i]   <= r_stg_err[i-1];
      end
   end

   // Stage 0 always takes the accepted request, even during flush: that
   // request is the redirect target. Older stages are wiped by flush.
   always_comb begin
      w_stg_vld_nxt    = '0;
      w_stg_vld_nxt[0] = w_req_acc;
      for (int i = 1; i < LATENCY; i++) begin
         w_stg_vld_nxt[i] = r_stg_vld[i-1] && !flush;
      end
   end

   always_ff @(posedge clk or negedge rst) begin : stg_valid
      if (!rst) begin
         r_stg_vld <= '0;
      end else begin
         r_stg_vld <= w_stg_vld_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Response FIFO (show-ahead). Credits guarantee a push never finds
   // the FIFO full, so no full check is needed on the write side.
   // ------------------------------------------------------------------
   assign w_push = r_stg_vld[LATENCY-1] && !flush;
   assign w_pop  = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin : fifo_data
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= r_stg_instr[LATENCY-1];
         r_fifo_err[r_wr_ptr]   <= r_stg_err[LATENCY-1];
      end
   end

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
         w_cnt_nxt = r_cnt - 1'b1;
      end
   end

   // A pop in the flush cycle needs no special handling: the entry is
   // gone either way and the consumer already took it.
   always_ff @(posedge clk or negedge rst) begin : fifo_ctrl
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_cnt <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Credits: occupied slots are valid pipeline stages plus FIFO entries,
   // all registered, so a pop frees its credit one cycle later.
   // ------------------------------------------------------------------
   always_comb begin
      w_used = {1'b0, r_cnt};
      for (int i = 0; i < LATENCY; i++) begin
         w_used = w_used + {{CW{1'b0}}, r_stg_vld[i]};
      end
   end

   assign req_ready = (w_used < {1'b0, FD_CNT});

   // ------------------------------------------------------------------
   // Outputs: head of FIFO, forced to zero while empty so reset and idle
   // both present a clean bus.
   // ------------------------------------------------------------------
   assign rsp_valid = (r_cnt != '0);
   assign rsp_instr = rsp_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
   assign rsp_err   = rsp_valid & r_fifo_err[r_rd_ptr];

endmodule

// File: tb/tb_instr_mem_resp.sv
module tb_instr_mem_resp;

   localparam int          DEPTH = 1024;
   localparam int          LAT   = 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush, ld_en;
   logic [31:0] req_addr, rsp_instr, ld_addr, ld_data;

   instr_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
      .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] instr; logic err; int mature; } exp_t;
   typedef struct { logic rv; logic [31:0] ra; logic rr; logic fl; logic le; logic [31:0] la; logic [31:0] ld; } stim_t;

   // Transaction-level reference: memory image plus the ordered list of
   // outstanding responses, each tagged with the edge where it may appear.
   exp_t        mq[$];
   logic [31:0] mdl_mem [DEPTH];
   logic [32:0] obs_q[$];
   logic [31:0] prog [4];
   int          edge_cnt = 0;
   int          dut_acc  = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic        exp_ready, exp_valid, exp_err;
   logic [31:0] exp_instr;

   function automatic exp_t mdl_resp(input logic [31:0] a);
      exp_t e;
      e.err    = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
      e.instr  = e.err ? NOP : mdl_mem[int'(a >> 2)];
      e.mature = 0;
      return e;
   endfunction

   function automatic void mdl_update();
      exp_ready = (mq.size() < LAT + 1);
      exp_valid = (mq.size() > 0) && (mq[0].mature <= edge_cnt);
      exp_instr = exp_valid ? mq[0].instr : 32'h0;
      exp_err   = exp_valid ? mq[0].err : 1'b0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{rv: 1'b0, ra: 32'h0, rr: 1'b0, fl: 1'b0, le: 1'b0, la: 32'h0, ld: 32'h0};
      return s;
   endfunction

   // Drives one cycle from a negedge to the next negedge and advances the model.
   task automatic cyc(input stim_t s);
      exp_t e;
      logic acc, pop;
      req_valid = s.rv; req_addr = s.ra; rsp_ready = s.rr; flush = s.fl;
      ld_en = s.le; ld_addr = s.la; ld_data = s.ld;
      acc = s.rv && exp_ready;
      pop = exp_valid && s.rr;
      if (s.rv && req_ready) dut_acc++;
      if (rsp_valid && s.rr) obs_q.push_back({rsp_err, rsp_instr});
      @(posedge clk);
      edge_cnt++;
      if (pop) mq.delete(0);
      if (s.fl) mq.delete();
      if (acc) begin
         e = mdl_resp(s.ra);
         e.mature = edge_cnt + LAT;
         mq.push_back(e);
      end
      if (s.le && s.la[1:0] == 2'b00 && (s.la >> 2) < DEPTH) mdl_mem[int'(s.la >> 2)] = s.ld;
      @(negedge clk);
      mdl_update();
   endtask

   task automatic test_reset();
      cyc_idle_inputs();
      rst = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_checks++;
      if (rsp_instr !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_instr: got %h expected 00000000", rsp_instr); end
      n_checks++;
      if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      @(negedge clk);
      mq.delete();
      mdl_update();
   endtask

   task automatic cyc_idle_inputs();
      req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0; flush = 1'b0;
      ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
   endtask

   task automatic test_load_fetch();
      stim_t s;
      int k;
      obs_q.delete();
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.le = 1'b1; s.la = 32'(i * 4); s.ld = prog[i];
         cyc(s);
      end
      k = 0;
      for (int c = 0; c < 20; c++) begin
         s = idle(); s.rr = 1'b1;
         if (k < 4) begin s.rv = 1'b1; s.ra = 32'(k * 4); if (exp_ready) k++; end
         cyc(s);
         n_checks++;
         if (req_ready !== exp_ready) begin n_errors++; $display("FAIL fetch_req_ready: cycle %0d got %b expected %b", edge_cnt, req_ready, exp_ready); end
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL fetch_rsp_valid: cycle %0d got %b expected %b", edge_cnt, rsp_valid, exp_valid); end
         if (exp_valid && rsp_valid) begin
            n_checks++;
            if (rsp_instr !== exp_instr || rsp_err !== exp_err) begin n_errors++; $display("FAIL fetch_rsp: cycle %0d got %h/%b expected %h/%b", edge_cnt, rsp_instr, rsp_err, exp_instr, exp_err); end
         end
      end
      n_checks++;
      if (obs_q.size() != 4) begin n_errors++; $display("FAIL fetch_count: got %0d responses expected 4", obs_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== {1'b0, prog[i]}) begin n_errors++; $display("FAIL fetch_word%0d: got %h expected %h", i, obs_q[i], {1'b0, prog[i]}); end
      end
   endtask

   task automatic test_errors();
      stim_t s;
      logic [31:0] bad [4];
      int k;
      bad[0] = 32'h6; bad[1] = 32'(4 * DEPTH); bad[2] = 32'hFFFF_FFFC; bad[3] = 32'h0000_1003;
      obs_q.delete();
      k = 0;
      for (int c = 0; c < 16; c++) begin
         s = idle(); s.rr = 1'b1;
         if (k < 4) begin s.rv = 1'b1; s.ra = bad[k]; if (exp_ready) k++; end
         cyc(s);
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL err_rsp_valid: cycle %0d got %b expected %b", edge_cnt, rsp_valid, exp_valid); end
         if (exp_valid && rsp_valid) begin
            n_checks++;
            if (rsp_instr !== exp_instr || rsp_err !== exp_err) begin n_errors++; $display("FAIL err_rsp: cycle %0d got %h/%b expected %h/%b", edge_cnt, rsp_instr, rsp_err, exp_instr, exp_err); end
         end
      end
      n_checks++;
      if (obs_q.size() != 4) begin n_errors++; $display("FAIL err_count: got %0d responses expected 4", obs_q.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== {1'b1, NOP}) begin n_errors++; $display("FAIL err_word%0d: got %h expected %h", i, obs_q[i], {1'b1, NOP}); end
      end
   endtask

   task automatic test_backpressure();
      stim_t s;
      obs_q.delete();
      dut_acc = 0;
      for (int c = 0; c < 12; c++) begin
         s = idle();
         if (c < 6) begin s.rv = 1'b1; s.ra = 32'((c % 4) * 4); end
         else s.rr = 1'b1;
         cyc(s);
         n_checks++;
         if (req_ready !== exp_ready) begin n_errors++; $display("FAIL bp_req_ready: cycle %0d got %b expected %b", edge_cnt, req_ready, exp_ready); end
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL bp_rsp_valid: cycle %0d got %b expected %b", edge_cnt, rsp_valid, exp_valid); end
         if (exp_valid && rsp_valid) begin
            n_checks++;
            if (rsp_instr !== exp_instr || rsp_err !== exp_err) begin n_errors++; $display("FAIL bp_rsp: cycle %0d got %h/%b expected %h/%b", edge_cnt, rsp_instr, rsp_err, exp_instr, exp_err); end
         end
      end
      n_checks++;
      if (dut_acc != LAT + 1) begin n_errors++; $display("FAIL bp_accepts: got %0d expected %0d", dut_acc, LAT + 1); end
      n_checks++;
      if (obs_q.size() != LAT + 1) begin n_errors++; $display("FAIL bp_drain: got %0d responses expected %0d", obs_q.size(), LAT + 1); end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== {1'b0, prog[i % 4]}) begin n_errors++; $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], {1'b0, prog[i % 4]}); end
      end
   endtask

   task automatic test_flush();
      stim_t seq [11];
      for (int i = 0; i < 11; i++) seq[i] = idle();
      seq[0].rv = 1'b1; seq[0].ra = 32'h0;
      seq[1].rv = 1'b1; seq[1].ra = 32'h4;
      seq[2].rv = 1'b1; seq[2].ra = 32'h8; seq[2].fl = 1'b1;
      seq[3].rv = 1'b1; seq[3].ra = 32'h8; seq[3].rr = 1'b1;
      seq[4].rr = 1'b1; seq[5].rr = 1'b1;
      seq[6].rv = 1'b1; seq[6].ra = 32'h0;
      seq[7].rv = 1'b1; seq[7].ra = 32'h8; seq[7].fl = 1'b1;
      seq[8].rr = 1'b1; seq[9].rr = 1'b1; seq[10].rr = 1'b1;
      obs_q.delete();
      for (int i = 0; i < 11; i++) begin
         cyc(seq[i]);
         n_checks++;
         if (req_ready !== exp_ready) begin n_errors++; $display("FAIL flush_req_ready: step %0d got %b expected %b", i, req_ready, exp_ready); end
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL flush_rsp_valid: step %0d got %b expected %b", i, rsp_valid, exp_valid); end
         if (exp_valid && rsp_valid) begin
            n_checks++;
            if (rsp_instr !== exp_instr) begin n_errors++; $display("FAIL flush_rsp: step %0d got %h expected %h", i, rsp_instr, exp_instr); end
         end
      end
      n_checks++;
      if (obs_q.size() != 2) begin n_errors++; $display("FAIL flush_count: got %0d responses expected 2", obs_q.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== {1'b0, 32'h002081B3}) begin n_errors++; $display("FAIL flush_word%0d: got %h expected 0002081b3", i, obs_q[i]); end
      end
   endtask

   task automatic test_collision();
      stim_t s;
      obs_q.delete();
      for (int c = 0; c < 5; c++) begin
         s = idle(); s.rr = 1'b1;
         if (c == 0) begin s.rv = 1'b1; s.ra = 32'h4; s.le = 1'b1; s.la = 32'h4; s.ld = 32'hDEAD_BEEF; end
         if (c == 1) begin s.rv = 1'b1; s.ra = 32'h4; end
         cyc(s);
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL coll_rsp_valid: step %0d got %b expected %b", c, rsp_valid, exp_valid); end
         if (exp_valid && rsp_valid) begin
            n_checks++;
            if (rsp_instr !== exp_instr) begin n_errors++; $display("FAIL coll_rsp: step %0d got %h expected %h", c, rsp_instr, exp_instr); end
         end
      end
      n_checks++;
      if (obs_q.size() != 2) begin n_errors++; $display("FAIL coll_count: got %0d expected 2", obs_q.size()); end
      else begin
         n_checks++;
         if (obs_q[0] !== {1'b0, 32'h00A00113}) begin n_errors++; $display("FAIL coll_old: got %h expected 000a00113", obs_q[0]); end
         n_checks++;
         if (obs_q[1] !== {1'b0, 32'hDEADBEEF}) begin n_errors++; $display("FAIL coll_new: got %h expected 0deadbeef", obs_q[1]); end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s;
      for (int c = 0; c < 3; c++) begin
         s = idle();
         if (c < 2) begin s.rv = 1'b1; s.ra = 32'(c * 4); end
         cyc(s);
      end
      n_checks++;
      if (rsp_valid !== 1'b1 || mq.size() != 2) begin n_errors++; $display("FAIL rstmid_fill: rsp_valid %b model depth %0d expected 1/2", rsp_valid, mq.size()); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_async: rsp_valid got %b expected 0", rsp_valid); end
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
      mdl_update();
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
      obs_q.delete();
      for (int c = 0; c < 4; c++) begin
         s = idle(); s.rr = 1'b1;
         if (c == 0) begin s.rv = 1'b1; s.ra = 32'h0; end
         cyc(s);
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL rstmid_rsp_valid: step %0d got %b expected %b", c, rsp_valid, exp_valid); end
      end
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 32'h00500093}) begin n_errors++; $display("FAIL rstmid_word: got %0d responses, first %h expected 1 of 000500093", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 33'h0); end
   endtask

   task automatic test_random();
      stim_t s;
      int r;
      for (int i = 0; i < 64; i++) begin
         s = idle(); s.le = 1'b1; s.la = 32'(i * 4); s.ld = $urandom;
         cyc(s);
      end
      for (int c = 0; c < 600; c++) begin
         s = idle();
         s.rv = ($urandom_range(3) != 0);
         r = $urandom_range(19);
         if (r < 16)      s.ra = 32'($urandom_range(63) * 4);
         else if (r < 18) s.ra = 32'($urandom_range(63) * 4 + $urandom_range(3, 1));
         else             s.ra = 32'(4 * DEPTH) + 32'($urandom_range(4095));
         s.rr = (c >= 590) || ($urandom_range(3) != 0);
         s.fl = (c < 590) && ($urandom_range(24) == 0);
         if ($urandom_range(3) == 0) begin
            s.le = 1'b1;
            s.la = ($urandom_range(7) == 0) ? 32'($urandom_range(63) * 4 + 2) : 32'($urandom_range(63) * 4);
            s.ld = $urandom;
         end
         cyc(s);
         n_checks++;
         if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rand_req_ready: cycle %0d got %b expected %b", edge_cnt, req_ready, exp_ready); end
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_errors++; $display("FAIL rand_rsp_valid: cycle %0d got %b expected %b", edge_cnt, rsp_valid, exp_valid); end
         if (exp_valid && rsp_valid) begin
            n_checks++;
            if (rsp_instr !== exp_instr || rsp_err !== exp_err) begin n_errors++; $display("FAIL rand_rsp: cycle %0d got %h/%b expected %h/%b", edge_cnt, rsp_instr, rsp_err, exp_instr, exp_err); end
         end
      end
   endtask

   initial begin
      prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
      prog[2] = 32'h002081B3; prog[3] = 32'h0000006F;
      exp_ready = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_instr = 32'h0;
      test_reset();
      test_load_fetch();
      test_errors();
      test_backpressure();
      test_flush();
      test_collision();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
